// File: rtl/param_stream_pkg.sv
// rtl/param_stream_pkg.sv - shared types and defaults for the parameter vector streamer
package param_stream_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} pvs_state_t;

  localparam int DEFAULT_MEM_DEPTH = 768;

endpackage

// File: rtl/vector_ram.sv
// rtl/vector_ram.sv - 1W1R synchronous vector storage, one-cycle read latency
module vector_ram #(
  parameter int D_W = 32,
  parameter int MEM_DEPTH = 768,
  localparam int ADDR_W = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [D_W-1:0]    wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [D_W-1:0]    rd_data
);

  logic [D_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/param_vector_streamer.sv
// rtl/param_vector_streamer.sv - replays a stored parameter vector as a DIM1 x DIM2 stream
module param_vector_streamer
  import param_stream_pkg::*;
#(
  parameter int D_W = 32,
  parameter int MATRIXSIZE_W = 24,
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  localparam int ADDR_W = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [D_W-1:0]          wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [D_W-1:0]          out_vec_tdata,
  output logic                    out_vec_tvalid,
  input  logic                    out_vec_tready,
  output logic                    out_vec_tlast,
  input  logic [MATRIXSIZE_W-1:0] DIM1,
  input  logic [MATRIXSIZE_W-1:0] DIM2
);

  localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

  pvs_state_t state_q, state_d;
  logic [MATRIXSIZE_W-1:0] dim1_q, dim2_q, row_q, col_q;
  logic                    rd_valid_q, rd_last_q;
  logic [1:0]              skid_cnt_q;
  logic [D_W:0]            skid0_q, skid1_q;
  logic                    done_q, err_q;
  logic [D_W-1:0]          ram_rdata;
  logic [D_W:0]            rd_entry;
  logic                    issue, rd_is_last, space, pop;
  logic                    start_acc, dims_bad, wr_bad, wr_ok;

  assign start_acc  = start && (state_q == IDLE);
  assign dims_bad   = (DIM1 == '0) || (DIM2 == '0) || (32'(DIM2) > 32'(MEM_DEPTH));
  assign wr_bad     = wr_en && ((state_q != IDLE) || (32'(wr_addr) >= 32'(MEM_DEPTH)));
  assign wr_ok      = wr_en && !wr_bad;
  assign rd_is_last = (row_q == dim1_q - ONE) && (col_q == dim2_q - ONE);
  // Reads are only issued when the skid buffer can absorb every outstanding beat.
  assign space      = ({1'b0, rd_valid_q} + skid_cnt_q) < 2'd2;
  assign rd_entry   = {rd_last_q, ram_rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE:   if (start && !dims_bad) state_d = PRIME;
      PRIME: begin
        issue   = 1'b1;
        state_d = rd_is_last ? DRAIN : STREAM;
      end
      STREAM: if (space) begin
        issue = 1'b1;
        if (rd_is_last) state_d = DRAIN;
      end
      DRAIN:  if (pop && out_vec_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dim1_q <= '0;
      dim2_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (start_acc) begin
      dim1_q <= DIM1;
      dim2_q <= DIM2;
      row_q  <= '0;
      col_q  <= '0;
    end else if (issue) begin
      if (col_q == dim2_q - ONE) begin
        col_q <= '0;
        row_q <= row_q + ONE;
      end else begin
        col_q <= col_q + ONE;
      end
    end
  end

  vector_ram #(.D_W(D_W), .MEM_DEPTH(MEM_DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (col_q[ADDR_W-1:0]),
    .rd_data (ram_rdata)
  );

  // The RAM output acts as the beat behind the skid entries, so a fresh read is visible one cycle after issue.
  assign out_vec_tvalid = (skid_cnt_q != 2'd0) || rd_valid_q;
  assign {out_vec_tlast, out_vec_tdata} = (skid_cnt_q != 2'd0) ? skid0_q :
                                          rd_valid_q ? rd_entry : '0;
  assign pop = out_vec_tvalid && out_vec_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      rd_valid_q <= issue;
      rd_last_q  <= issue && rd_is_last;
      case (skid_cnt_q)
        2'd0: if (rd_valid_q && !pop) begin
          skid0_q    <= rd_entry;
          skid_cnt_q <= 2'd1;
        end
        2'd1: if (pop) begin
          if (rd_valid_q) skid0_q    <= rd_entry;
          else            skid_cnt_q <= 2'd0;
        end else if (rd_valid_q) begin
          skid1_q    <= rd_entry;
          skid_cnt_q <= 2'd2;
        end
        2'd2: if (pop) begin
          skid0_q    <= skid1_q;
          skid_cnt_q <= 2'd1;
        end
        default: skid_cnt_q <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (start_acc && dims_bad) || ((state_q == DRAIN) && pop && out_vec_tlast);
      err_q  <= (err_q && !start_acc) || (start_acc && dims_bad) || wr_bad;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_param_vector_streamer.sv
// tb/tb_param_vector_streamer.sv - self-checking bench with a beat-queue reference model
module tb_param_vector_streamer;

  localparam int DEPTH = 768;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        tready = 1'b0;
  logic [23:0] dim1 = '0, dim2 = '0;
  logic        busy, done, err, tvalid, tlast;
  logic [31:0] tdata;

  param_vector_streamer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .err(err),
    .out_vec_tdata(tdata), .out_vec_tvalid(tvalid), .out_vec_tready(tready),
    .out_vec_tlast(tlast), .DIM1(dim1), .DIM2(dim2)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  logic [32:0] exp_q [$];
  bit          m_busy = 0, m_err = 0, m_done_next = 0, prev_hold = 0;
  logic [32:0] prev_beat;
  int          first_valid_cyc = -1;
  int          hs_cyc [$];
  logic [32:0] hs_beat [$];
  int          done_cyc [$];

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_busy = 0; m_err = 0; m_done_next = 0; prev_hold = 0; first_valid_cyc = -1;
    end else begin
      bit done_n, busy_n, err_n, wbad;
      chk("done", done, m_done_next);
      chk("busy", busy, m_busy);
      chk("err", err, m_err);
      if (done) done_cyc.push_back(cyc);
      if (prev_hold) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_beat", {tlast, tdata}, prev_beat);
      end
      if (first_valid_cyc == cyc) chk("first_latency", tvalid, 1);
      if (!m_busy) chk("idle_no_valid", tvalid, 0);
      done_n = 0; busy_n = m_busy; err_n = m_err;
      if (tvalid && tready) begin
        hs_cyc.push_back(cyc);
        hs_beat.push_back({tlast, tdata});
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("beat", {tlast, tdata}, e);
          if (e[32]) begin done_n = 1; busy_n = 0; end
        end
      end
      prev_hold = tvalid && !tready;
      prev_beat = {tlast, tdata};
      wbad = wr_en && (m_busy || wr_addr >= DEPTH);
      if (wbad) err_n = 1;
      else if (wr_en) mem_m[wr_addr] = wr_data;
      if (start && !m_busy) begin
        if (dim1 == 0 || dim2 == 0 || dim2 > DEPTH) begin
          done_n = 1; err_n = 1;
        end else begin
          err_n = wbad;
          busy_n = 1;
          first_valid_cyc = cyc + 2;
          for (int r = 0; r < int'(dim1); r++)
            for (int c = 0; c < int'(dim2); c++)
              exp_q.push_back({(r == int'(dim1) - 1) && (c == int'(dim2) - 1), mem_m[c]});
        end
      end
      m_done_next = done_n; m_busy = busy_n; m_err = err_n;
    end
  end

  bit ready_auto = 0;
  int ready_pct = 100;
  always @(posedge clk) begin
    #1;
    if (ready_auto) tready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    wr_en = 1; wr_addr = 10'(addr); wr_data = data;
    step();
    wr_en = 0;
  endtask

  task automatic launch(input int d1, input int d2, output int t);
    dim1 = 24'(d1); dim2 = 24'(d2); start = 1; t = cyc;
    step();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    bit seen;
    n0 = done_cyc.size();
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done_cyc.size() > n0) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    step(2);
  endtask

  task automatic clear_logs();
    hs_cyc.delete(); hs_beat.delete(); done_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t, nlast;
    step(3);
    chk("rst_tvalid", tvalid, 0); chk("rst_tlast", tlast, 0); chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    rst = 1;
    step(2);

    // Full-depth vector, two rows, no backpressure
    for (int i = 0; i < DEPTH; i++) wr(i, 32'(i + 100));
    tready = 1;
    clear_logs();
    launch(2, 768, t);
    wait_done(2000);
    chk("t1_beats", hs_beat.size(), 1536);
    if (hs_beat.size() == 1536) begin
      chk("t1_first", hs_beat[0], {1'b0, 32'd100});
      chk("t1_row0_end", hs_beat[767], {1'b0, 32'd867});
      chk("t1_row1_start", hs_beat[768], {1'b0, 32'd100});
      chk("t1_last", hs_beat[1535], {1'b1, 32'd867});
      chk("t1_first_cycle", hs_cyc[0], t + 2);
      chk("t1_no_bubbles", hs_cyc[1535] - hs_cyc[0], 1535);
      chk("t1_done_cycle", done_cyc.size() > 0 ? done_cyc[0] : -1, hs_cyc[1535] + 1);
    end

    // Short vector under 30% ready, with a start ignored mid-pass
    wr(0, 7); wr(1, 8); wr(2, 9); wr(3, 10);
    clear_logs();
    ready_pct = 30; ready_auto = 1;
    launch(3, 4, t);
    step(3);
    start = 1; step(); start = 0;
    wait_done(500);
    ready_auto = 0; tready = 1;
    chk("t2_beats", hs_beat.size(), 12);
    nlast = 0;
    foreach (hs_beat[i]) if (hs_beat[i][32]) nlast++;
    chk("t2_tlast_count", nlast, 1);
    if (hs_beat.size() == 12) begin
      chk("t2_beat5", hs_beat[4], {1'b0, 32'd7});
      chk("t2_beat12", hs_beat[11], {1'b1, 32'd10});
    end

    // Bad dimensions
    clear_logs();
    launch(1, 0, t);
    step(2);
    chk("t3_done_t1", done_cyc.size() > 0 ? done_cyc[0] : -1, t + 1);
    chk("t3_err", err, 1);
    chk("t3_no_beats", hs_beat.size(), 0);
    launch(1, 4, t);
    wait_done(100);
    chk("t3_err_cleared", err, 0);
    clear_logs();
    launch(2, 769, t);
    step(2);
    chk("t3b_done_t1", done_cyc.size() > 0 ? done_cyc[0] : -1, t + 1);
    chk("t3b_err", err, 1);
    launch(0, 4, t);
    step(2);
    chk("t3c_err", err, 1);
    wr(800, 32'h1234);
    launch(1, 4, t);
    wait_done(100);
    chk("t3c_err_cleared", err, 0);

    // Write during a pass is dropped; write with start lands in the pass
    clear_logs();
    launch(2, 4, t);
    step(2);
    wr(0, 32'hDEAD);
    wait_done(100);
    chk("t4_err", err, 1);
    chk("t4_mem0", hs_beat.size() > 0 ? hs_beat[0] : '0, {1'b0, 32'd7});
    clear_logs();
    wr_en = 1; wr_addr = 10'd1; wr_data = 32'd55;
    launch(1, 4, t);
    wr_en = 0;
    wait_done(100);
    chk("t4_err_cleared", err, 0);
    if (hs_beat.size() == 4) begin
      chk("t4_next_mem0", hs_beat[0], {1'b0, 32'd7});
      chk("t4_same_cycle_write", hs_beat[1], {1'b0, 32'd55});
    end else chk("t4_beats", hs_beat.size(), 4);
    wr(1, 8);

    // Asynchronous reset mid-pass at beat 5 with tready low
    clear_logs();
    launch(3, 4, t);
    for (int i = 0; i < 50 && hs_beat.size() < 5; i++) step();
    chk("t5_reached_beat5", hs_beat.size(), 5);
    tready = 0;
    step(2);
    #2 rst = 0;
    #1;
    chk("t5_rst_tvalid", tvalid, 0); chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0); chk("t5_rst_tdata", tdata, 0);
    step(2);
    rst = 1;
    step();
    tready = 1;
    clear_logs();
    launch(3, 4, t);
    wait_done(100);
    chk("t5_beats", hs_beat.size(), 12);
    if (hs_beat.size() == 12) begin
      chk("t5_beat0", hs_beat[0], {1'b0, 32'd7});
      chk("t5_beat12", hs_beat[11], {1'b1, 32'd10});
    end

    // Randomized passes against the model
    ready_pct = 50; ready_auto = 1;
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 6; a++) wr(a, $urandom);
      launch($urandom_range(1, 4), $urandom_range(1, 6), t);
      wait_done(300);
    end
    ready_auto = 0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
